// File: rtl/axi_channel_fifo.sv
// Valid/ready FIFO for one AXI channel: first-word-fall-through, with an optional
// store-and-forward packet mode keyed on the stored last flag.
module axi_channel_fifo #(
  parameter int C_DATA_WIDTH          = 32,
  parameter int C_FIFO_DEPTH          = 16,
  parameter int C_PACKET_MODE         = 0,
  parameter int C_ALMOST_FULL_THRESH  = C_FIFO_DEPTH - 2,
  parameter int C_ALMOST_EMPTY_THRESH = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [C_DATA_WIDTH-1:0]       s_data,
  input  logic                          s_last,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [C_DATA_WIDTH-1:0]       m_data,
  output logic                          m_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(C_FIFO_DEPTH):0] count,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty
);

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE_C = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] DEPTH_C    = CW'(C_FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C       = CW'(C_ALMOST_FULL_THRESH);
  localparam logic [CW-1:0] AE_C       = CW'(C_ALMOST_EMPTY_THRESH);

  logic [C_DATA_WIDTH:0] mem_q [C_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, pkt_cnt_q, pkt_cnt_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          afull_q, afull_d, aempty_q, aempty_d;
  logic          s_ready_q, s_ready_d, override_q, override_d;
  logic          wr_s, rd_s, pkt_inc_s, pkt_dec_s, m_valid_s;

  // Head entry falls through to the output; packet mode gates validity.
  always_comb begin
    {m_last, m_data} = mem_q[rd_ptr_q];
    if (C_PACKET_MODE != 0) begin
      m_valid_s = !empty_q && ((pkt_cnt_q != CNT_ZERO_C) || override_q);
    end else begin
      m_valid_s = !empty_q;
    end
  end

  // Next-state computation for pointers, occupancy, flags and packet tracking.
  always_comb begin
    wr_s      = s_valid && s_ready_q;
    rd_s      = m_valid_s && m_ready;
    pkt_inc_s = wr_s && s_last;
    pkt_dec_s = rd_s && m_last;
    wr_ptr_d  = wr_s ? (wr_ptr_q + PTR_ONE_C) : wr_ptr_q;
    rd_ptr_d  = rd_s ? (rd_ptr_q + PTR_ONE_C) : rd_ptr_q;

    case ({wr_s, rd_s})
      2'b10:   count_d = count_q + CNT_ONE_C;
      2'b01:   count_d = count_q - CNT_ONE_C;
      default: count_d = count_q;
    endcase

    case ({pkt_inc_s, pkt_dec_s})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_ONE_C;
      2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_ONE_C;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase

    // A full FIFO holding no complete packet can never release one: drain cut-through.
    if (C_PACKET_MODE == 0) begin
      override_d = 1'b0;
    end else if (pkt_dec_s) begin
      override_d = 1'b0;
    end else if (full_q && (pkt_cnt_q == CNT_ZERO_C)) begin
      override_d = 1'b1;
    end else begin
      override_d = override_q;
    end

    full_d    = (count_d == DEPTH_C);
    empty_d   = (count_d == CNT_ZERO_C);
    afull_d   = (count_d >= AF_C);
    aempty_d  = (count_d <= AE_C);
    s_ready_d = !full_d;
  end

  // Payload storage; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= {s_last, s_data};
    end
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= CNT_ZERO_C;
      pkt_cnt_q  <= CNT_ZERO_C;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      s_ready_q  <= 1'b0;
      override_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pkt_cnt_q  <= pkt_cnt_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      s_ready_q  <= s_ready_d;
      override_q <= override_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign m_valid      = m_valid_s;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;

endmodule

// File: tb/tb_axi_channel_fifo.sv
// Bench for axi_channel_fifo: a FWFT and a packet-mode instance share stimulus and are
// checked every cycle against a queue-level model, plus hand-computed expectations.
module tb_axi_channel_fifo;

  localparam int W = 8;
  localparam int D = 16;

  logic       clk, resetn;
  logic [W-1:0] s_data;
  logic       s_last, s_valid, m_ready;
  logic [1:0] sready_o, mlast_o, mvalid_o, full_o, empty_o, af_o, ae_o;
  logic [W-1:0] mdata_o [2];
  logic [4:0] cnt_o [2];

  int checks = 0;
  int errors = 0;

  axi_channel_fifo #(.C_DATA_WIDTH(W), .C_FIFO_DEPTH(D), .C_PACKET_MODE(0)) u_fwft (
    .clk(clk), .resetn(resetn), .s_data(s_data), .s_last(s_last), .s_valid(s_valid),
    .s_ready(sready_o[0]), .m_data(mdata_o[0]), .m_last(mlast_o[0]), .m_valid(mvalid_o[0]),
    .m_ready(m_ready), .count(cnt_o[0]), .full(full_o[0]), .empty(empty_o[0]),
    .almost_full(af_o[0]), .almost_empty(ae_o[0]));

  axi_channel_fifo #(.C_DATA_WIDTH(W), .C_FIFO_DEPTH(D), .C_PACKET_MODE(1)) u_pkt (
    .clk(clk), .resetn(resetn), .s_data(s_data), .s_last(s_last), .s_valid(s_valid),
    .s_ready(sready_o[1]), .m_data(mdata_o[1]), .m_last(mlast_o[1]), .m_valid(mvalid_o[1]),
    .m_ready(m_ready), .count(cnt_o[1]), .full(full_o[1]), .empty(empty_o[1]),
    .almost_full(af_o[1]), .almost_empty(ae_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: unbounded store with head/tail indices per instance.
  logic [W:0] store [2][256];
  int  head [2];
  int  tail [2];
  int  pkt  [2];
  bit  ovr  [2];
  bit  srm  [2];

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h expected %0h", nm, k, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      head[k] = 0; tail[k] = 0; pkt[k] = 0; ovr[k] = 1'b0; srm[k] = 1'b0;
    end
  endtask

  function automatic bit exp_mvalid(input int k);
    return ((tail[k] - head[k]) != 0) && ((k == 0) || (pkt[k] != 0) || ovr[k]);
  endfunction

  task automatic model_step();
    bit wr, rd, hl, fullb;
    int pb;
    for (int k = 0; k < 2; k++) begin
      wr    = s_valid && srm[k];
      rd    = exp_mvalid(k) && m_ready;
      hl    = store[k][head[k] % 256][W];
      fullb = ((tail[k] - head[k]) == D);
      pb    = pkt[k];
      if (wr) begin
        store[k][tail[k] % 256] = {s_last, s_data};
        tail[k]++;
      end
      if (rd) head[k]++;
      if (wr && s_last) pkt[k]++;
      if (rd && hl) pkt[k]--;
      if (k == 1) begin
        if (rd && hl) ovr[k] = 1'b0;
        else if (fullb && pb == 0) ovr[k] = 1'b1;
      end
      srm[k] = ((tail[k] - head[k]) != D);
    end
  endtask

  task automatic check_all();
    int n;
    for (int k = 0; k < 2; k++) begin
      n = tail[k] - head[k];
      chk("count", k, 32'(cnt_o[k]), 32'(n));
      chk("full", k, 32'(full_o[k]), 32'(n == D));
      chk("empty", k, 32'(empty_o[k]), 32'(n == 0));
      chk("almost_full", k, 32'(af_o[k]), 32'(n >= D - 2));
      chk("almost_empty", k, 32'(ae_o[k]), 32'(n <= 2));
      chk("s_ready", k, 32'(sready_o[k]), 32'(srm[k]));
      chk("m_valid", k, 32'(mvalid_o[k]), 32'(exp_mvalid(k)));
      if (exp_mvalid(k)) begin
        chk("m_data", k, 32'(mdata_o[k]), 32'(store[k][head[k] % 256][W-1:0]));
        chk("m_last", k, 32'(mlast_o[k]), 32'(store[k][head[k] % 256][W]));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (resetn) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0; s_data = 8'h00;
    model_reset();
    tick();
    tick();
    resetn = 1'b1;
    #1;
    chk("s_ready_at_release", 1, 32'(sready_o[1]), 32'd0);
    tick();
    chk("s_ready_after_edge", 0, 32'(sready_o[0]), 32'd1);
  endtask

  initial begin
    int rx [2];
    int idx, rcv;
    resetn = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0; s_data = 8'h00;
    model_reset();

    // Reset state and fill to full.
    do_reset();
    chk("empty_after_reset", 0, 32'(empty_o[0]), 32'd1);
    chk("count_after_reset", 0, 32'(cnt_o[0]), 32'd0);
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = W'(i); s_last = 1'b0;
      tick();
      chk("af_threshold", 0, 32'(af_o[0]), 32'(i + 1 >= 14));
    end
    chk("count_full", 0, 32'(cnt_o[0]), 32'd16);
    chk("full_flag", 0, 32'(full_o[0]), 32'd1);
    chk("s_ready_full", 0, 32'(sready_o[0]), 32'd0);
    s_data = 8'hAA;
    tick();
    tick();
    s_valid = 1'b0;
    rx[0] = 0; rx[1] = 0;
    for (int c = 0; c < 60 && (rx[0] < 16 || rx[1] < 16); c++) begin
      m_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (mvalid_o[k]) begin
          chk("drain_order", k, 32'(mdata_o[k]), 32'(rx[k]));
          rx[k]++;
        end
      end
      tick();
    end
    chk("drain_count", 0, 32'(rx[0]), 32'd16);
    chk("drain_count", 1, 32'(rx[1]), 32'd16);
    chk("empty_after_drain", 0, 32'(empty_o[0]), 32'd1);

    // Continuous streaming, pointers wrap twice.
    do_reset();
    rcv = 0;
    for (int i = 0; i < 40; i++) begin
      s_valid = 1'b1; s_data = W'(8'h20 + i); s_last = 1'b0; m_ready = 1'b1;
      if (i >= 1) chk("stream_count", 0, 32'(cnt_o[0]), 32'd1);
      if (mvalid_o[0]) begin
        chk("stream_order", 0, 32'(mdata_o[0]), 32'(8'h20 + rcv));
        rcv++;
      end
      tick();
    end
    s_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (mvalid_o[0]) begin
        chk("stream_order", 0, 32'(mdata_o[0]), 32'(8'h20 + rcv));
        rcv++;
      end
      tick();
    end
    chk("stream_total", 0, 32'(rcv), 32'd40);

    // Packet mode: three-beat packet is held until its last beat is stored.
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = W'(8'h50 + i); s_last = (i == 2);
      chk("pkt_held", 1, 32'(mvalid_o[1]), 32'd0);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("pkt_release", 1, 32'(mvalid_o[1]), 32'd1);
    rcv = 0;
    for (int c = 0; c < 10 && rcv < 3; c++) begin
      if (mvalid_o[1]) begin
        chk("pkt_data", 1, 32'(mdata_o[1]), 32'(8'h50 + rcv));
        chk("pkt_last", 1, 32'(mlast_o[1]), 32'(rcv == 2));
        rcv++;
      end
      tick();
    end
    chk("pkt_beats", 1, 32'(rcv), 32'd3);

    // Packet longer than the depth drains cut-through.
    do_reset();
    idx = 0; rcv = 0;
    for (int c = 0; c < 200 && (idx < 20 || rcv < 20); c++) begin
      s_valid = (idx < 20); s_data = W'(8'h60 + idx); s_last = (idx == 19);
      m_ready = (c >= 20);
      if (mvalid_o[1] && m_ready) begin
        chk("long_data", 1, 32'(mdata_o[1]), 32'(8'h60 + rcv));
        chk("long_last", 1, 32'(mlast_o[1]), 32'(rcv == 19));
        rcv++;
      end
      if (s_valid && sready_o[1]) idx++;
      tick();
    end
    chk("long_written", 1, 32'(idx), 32'd20);
    chk("long_delivered", 1, 32'(rcv), 32'd20);
    s_valid = 1'b1; s_data = 8'h7F; s_last = 1'b0; m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("override_cleared", 1, 32'(mvalid_o[1]), 32'd0);
      tick();
    end

    // Reset mid-burst discards contents immediately.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1; s_data = W'(8'h30 + i); s_last = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    chk("count_before_reset", 0, 32'(cnt_o[0]), 32'd7);
    resetn = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_count", k, 32'(cnt_o[k]), 32'd0);
      chk("reset_empty", k, 32'(empty_o[k]), 32'd1);
      chk("reset_mvalid", k, 32'(mvalid_o[k]), 32'd0);
    end
    tick();
    resetn = 1'b1;
    tick();
    tick();
    s_valid = 1'b1; s_data = 8'h99; s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    chk("post_reset_head", 0, 32'(mdata_o[0]), 32'h99);
    chk("post_reset_head", 1, 32'(mdata_o[1]), 32'h99);
    m_ready = 1'b1;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
